aes_out_serializer: RTL

Downstream stage of the AES-128 round controller. Captures each 128-bit ciphertext block on the controller's one-cycle `Done` pulse and buffers it in a small block FIFO. Streams each block out as 32-bit words over a valid/ready interface, most-significant word first. Returns `Full` to the top level, which gates the controller's `Valid` so blocks are not dropped.

---
 rtl/aes_out_serializer_pkg.sv | 16 +
 rtl/aes_out_serializer_if.sv | 28 ++
 rtl/aes_out_serializer_blk_fifo.sv | 62 ++++++
 rtl/aes_out_serializer.sv | 108 ++++++++++
 4 files changed

// File: rtl/aes_out_serializer_pkg.sv
// Shared types and widths for the AES output serializer: block/word sizes,
// the serializer state enum and the ciphertext block type.
package aes_pkg;

  localparam int BLOCK_W       = 128;
  localparam int WORD_W        = 32;
  localparam int WORDS_PER_BLK = BLOCK_W / WORD_W;

  typedef enum logic {
    EMPTY = 1'b0,
    SEND  = 1'b1
  } ser_state_t;

  typedef logic [BLOCK_W-1:0] aes_blk_t;

endpackage

// File: rtl/aes_out_serializer_if.sv
// Block-capture and word-stream signals between the round controller, the
// serializer and the downstream consumer.
interface aes_out_serializer_if #(
  parameter int BLOCK_W = aes_pkg::BLOCK_W,
  parameter int WORD_W  = aes_pkg::WORD_W
);

  logic               Done;
  logic [BLOCK_W-1:0] Cipher_Txt;
  logic               Out_Valid;
  logic               Out_Ready;
  logic [WORD_W-1:0]  Out_Data;
  logic               Out_Last;
  logic               Full;
  logic               Overflow;

  // The serializer is the master of the word stream.
  modport master (
    input  Done, Cipher_Txt, Out_Ready,
    output Out_Valid, Out_Data, Out_Last, Full, Overflow
  );

  modport slave (
    output Done, Cipher_Txt, Out_Ready,
    input  Out_Valid, Out_Data, Out_Last, Full, Overflow
  );

endinterface

// File: rtl/aes_out_serializer_blk_fifo.sv
// Block FIFO holding whole ciphertext blocks; the head block is exposed
// combinationally from storage, with no knowledge of words.
module aes_blk_fifo #(
  parameter int BLOCK_W = aes_pkg::BLOCK_W,
  parameter int DEPTH   = 2
) (
  input  logic                       CLK,
  input  logic                       rst,
  input  logic                       push,
  input  logic [BLOCK_W-1:0]         push_data,
  input  logic                       pop,
  output logic [BLOCK_W-1:0]         head_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [BLOCK_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               wr_en;
  logic               rd_en;

  // A push into a full FIFO is still legal when the head leaves this cycle.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap at DEPTH, which is a power of two; DEPTH==1 pins them at 0.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= (DEPTH == 1) ? '0 : wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= (DEPTH == 1) ? '0 : rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/aes_out_serializer.sv
// Captures ciphertext blocks on Done, buffers them, and streams each block
// as MSW-first words over valid/ready with a sticky drop flag.
module aes_out_serializer #(
  parameter int BLOCK_W = aes_pkg::BLOCK_W,
  parameter int WORD_W  = aes_pkg::WORD_W,
  parameter int DEPTH   = 2
) (
  input logic                   CLK,
  input logic                   rst,
  aes_out_serializer_if.master  bus
);

  import aes_pkg::*;

  localparam int WORDS  = BLOCK_W / WORD_W;
  localparam int WCNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(WORDS - 1);

  generate
    if ((BLOCK_W % WORD_W) != 0 || DEPTH < 1 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
      $error("aes_out_serializer: BLOCK_W must be a multiple of WORD_W and DEPTH a power of two");
    end
  endgenerate

  ser_state_t         state;
  logic [WCNT_W-1:0]  wcnt;
  logic               overflow_q;
  logic [BLOCK_W-1:0] head;
  logic [CNT_W-1:0]   count;
  logic               fifo_full;
  logic               fifo_empty;
  logic               xfer;
  logic               last_xfer;
  logic               push_ok;
  logic               drop;
  logic [WORD_W-1:0]  word;

  assign xfer      = (state == SEND) && !fifo_empty && bus.Out_Ready;
  assign last_xfer = xfer && (wcnt == LAST_WORD);
  assign push_ok   = bus.Done && (!fifo_full || last_xfer);
  assign drop      = bus.Done && fifo_full && !last_xfer;

  aes_blk_fifo #(
    .BLOCK_W (BLOCK_W),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .rst       (rst),
    .push      (push_ok),
    .push_data (bus.Cipher_Txt),
    .pop       (last_xfer),
    .head_data (head),
    .count     (count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Word k is taken from the top of the block downwards.
  always_comb begin
    word = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (wcnt == WCNT_W'(k)) begin
        word = head[BLOCK_W-1-k*WORD_W -: WORD_W];
      end
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      wcnt       <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (drop) begin
        overflow_q <= 1'b1;
      end
      case (state)
        EMPTY: begin
          if (push_ok) begin
            state <= SEND;
          end
        end
        SEND: begin
          if (xfer) begin
            if (wcnt == LAST_WORD) begin
              wcnt <= '0;
              if (!push_ok && count == CNT_W'(1)) begin
                state <= EMPTY;
              end
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Outputs decode only registered state, so data is zero whenever idle.
  assign bus.Out_Valid = (state == SEND);
  assign bus.Out_Data  = (state == SEND) ? word : '0;
  assign bus.Out_Last  = (state == SEND) && (wcnt == LAST_WORD);
  assign bus.Full      = fifo_full;
  assign bus.Overflow  = overflow_q;

endmodule
